// File: rtl/core_fetch.sv
// Instruction fetch unit: one outstanding memory read, kill-on-redirect, and a
// single-entry output buffer feeding the IF/ID register.
module core_fetch #(
  parameter int unsigned       W_ADDR   = 32,
  parameter int unsigned       W_INSTR  = 32,
  parameter logic [W_ADDR-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               i_fetch_clk,
  input  logic               i_fetch_rst_n,
  output logic               o_fetch_req,
  output logic [W_ADDR-1:0]  o_fetch_addr,
  input  logic               i_fetch_gnt,
  input  logic               i_fetch_rvalid,
  input  logic [W_INSTR-1:0] i_fetch_rdata,
  input  logic               i_fetch_stall,
  input  logic               i_fetch_redirect,
  input  logic [W_ADDR-1:0]  i_fetch_redirect_pc,
  output logic               o_fetch_valid,
  output logic [W_INSTR-1:0] o_fetch_instr,
  output logic [W_ADDR-1:0]  o_fetch_pc,
  output logic               o_fetch_clr,
  output logic [31:0]        o_fetch_count
);

  localparam logic [W_ADDR-1:0] LP_RESET_PC = {RESET_PC[W_ADDR-1:2], 2'b00};

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;

  state_t               r_state;
  logic [W_ADDR-1:0]    r_pc;
  logic                 r_kill;
  logic                 r_req;
  logic                 r_valid;
  logic [W_INSTR-1:0]   r_instr;
  logic [W_ADDR-1:0]    r_pc_out;
  logic [31:0]          r_count;

  logic [W_ADDR-1:0]    w_redir_pc;
  logic [W_ADDR-1:0]    w_pc_inc;
  logic                 w_unused_lsb;

  assign w_redir_pc   = {i_fetch_redirect_pc[W_ADDR-1:2], 2'b00};
  assign w_pc_inc     = r_pc + W_ADDR'(4);
  assign w_unused_lsb = ^i_fetch_redirect_pc[1:0];

  // The request address is the pc register itself, so it is always registered.
  assign o_fetch_req   = r_req;
  assign o_fetch_addr  = r_pc;
  assign o_fetch_valid = r_valid;
  assign o_fetch_instr = r_instr;
  assign o_fetch_pc    = r_pc_out;
  assign o_fetch_count = r_count;
  assign o_fetch_clr   = i_fetch_redirect;

  always_ff @(posedge i_fetch_clk or negedge i_fetch_rst_n) begin
    if (!i_fetch_rst_n) begin
      r_state  <= S_REQ;
      r_pc     <= LP_RESET_PC;
      r_kill   <= 1'b0;
      r_req    <= 1'b0;
      r_valid  <= 1'b0;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (i_fetch_redirect) r_pc <= w_redir_pc;
          // r_req is low only in the first cycle after reset; no grant is taken then.
          if (r_req && i_fetch_gnt) begin
            r_state <= S_WAIT;
            r_req   <= 1'b0;
            r_kill  <= i_fetch_redirect;
          end else begin
            r_req <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_fetch_rvalid) begin
            if (r_kill || i_fetch_redirect) begin
              r_kill  <= 1'b0;
              r_state <= S_REQ;
              r_req   <= 1'b1;
              if (i_fetch_redirect) r_pc <= w_redir_pc;
            end else begin
              r_instr  <= i_fetch_rdata;
              r_pc_out <= r_pc;
              r_pc     <= w_pc_inc;
              r_valid  <= 1'b1;
              r_state  <= S_VALID;
            end
          end else if (i_fetch_redirect) begin
            r_kill <= 1'b1;
            r_pc   <= w_redir_pc;
          end
        end
        S_VALID: begin
          if (i_fetch_redirect) begin
            r_pc    <= w_redir_pc;
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else if (!i_fetch_stall) begin
            r_valid <= 1'b0;
            r_req   <= 1'b1;
            r_count <= r_count + 32'd1;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_REQ;
          r_req   <= 1'b0;
          r_kill  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_fetch.sv
// Scoreboard bench for core_fetch: a behavioural memory drives gnt/rvalid,
// expected {pc,instr} pairs are queued at response time and popped on valid.
module tb_core_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        clr;
  logic [31:0] count;

  exp_t        sb[$];
  logic [31:0] mpc;
  logic [31:0] exp_count;
  int          n_checks = 0;
  int          n_pass = 0;

  core_fetch #(.W_ADDR(32), .W_INSTR(32), .RESET_PC(RST_PC)) dut (
    .i_fetch_clk(clk), .i_fetch_rst_n(rst_n),
    .o_fetch_req(req), .o_fetch_addr(addr),
    .i_fetch_gnt(gnt), .i_fetch_rvalid(rvalid), .i_fetch_rdata(rdata),
    .i_fetch_stall(stall), .i_fetch_redirect(redirect),
    .i_fetch_redirect_pc(redirect_pc),
    .o_fetch_valid(valid), .o_fetch_instr(instr), .o_fetch_pc(pc),
    .o_fetch_clr(clr), .o_fetch_count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Grant the pending request, respond after lat idle cycles, queue the expectation.
  task automatic fetch(input logic [31:0] data, input int lat, output bit ok);
    wait_req(ok);
    if (!ok) return;
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    repeat (lat) tick();
    sb.push_back('{pc: mpc, instr: data});
    mpc = mpc + 32'd4;
    rvalid = 1'b1;
    rdata  = data;
    tick();
    rvalid = 1'b0;
  endtask

  task automatic pop_exp(output exp_t e, output bit ok);
    ok = (sb.size() != 0);
    e  = ok ? sb.pop_front() : '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({req, valid, instr, pc, count, clr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0})
      $display("FAIL reset_vals: req=%b valid=%b instr=%h pc=%h count=%h clr=%b (want all 0)",
               req, valid, instr, pc, count, clr);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if ({req, addr} !== {1'b1, RST_PC})
      $display("FAIL first_req: req=%b addr=%h, want req=1 addr=%h", req, addr, RST_PC);
    else n_pass++;
    mpc = RST_PC;
    exp_count = '0;
  endtask

  task automatic test_basic();
    bit ok;
    exp_t e;
    fetch(32'h0000_0013, 2, ok);
    n_checks++;
    if (!ok) $display("FAIL basic_req_timeout: req=%b want 1", req); else n_pass++;
    pop_exp(e, ok);
    n_checks++;
    if (!ok || {valid, pc, instr} !== {1'b1, e.pc, e.instr})
      $display("FAIL basic_out: valid=%b pc=%h instr=%h, want 1 %h %h", valid, pc, instr, e.pc, e.instr);
    else n_pass++;
    tick();
    exp_count++;
    n_checks++;
    if ({valid, req, addr, count} !== {1'b0, 1'b1, mpc, exp_count})
      $display("FAIL basic_handoff: valid=%b req=%b addr=%h count=%h, want 0 1 %h %h",
               valid, req, addr, count, mpc, exp_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit ok;
    exp_t e;
    stall = 1'b1;
    fetch(32'hA5A5_0001, 1, ok);
    pop_exp(e, ok);
    n_checks++;
    if (!ok || {valid, pc, instr} !== {1'b1, e.pc, e.instr})
      $display("FAIL stall_out: valid=%b pc=%h instr=%h, want 1 %h %h", valid, pc, instr, e.pc, e.instr);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({valid, pc, instr, req, count} !== {1'b1, e.pc, e.instr, 1'b0, exp_count})
        $display("FAIL stall_hold%0d: valid=%b pc=%h instr=%h req=%b count=%h, want 1 %h %h 0 %h",
                 i, valid, pc, instr, req, count, e.pc, e.instr, exp_count);
      else n_pass++;
    end
    stall = 1'b0;
    tick();
    exp_count++;
    n_checks++;
    if ({req, addr, count} !== {1'b1, e.pc + 32'd4, exp_count})
      $display("FAIL stall_release: req=%b addr=%h count=%h, want 1 %h %h",
               req, addr, count, e.pc + 32'd4, exp_count);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      fetch($urandom, i, ok);
      pop_exp(e, ok);
      n_checks++;
      if (!ok || {valid, pc, instr} !== {1'b1, e.pc, e.instr})
        $display("FAIL b2b_out%0d: valid=%b pc=%h instr=%h, want 1 %h %h", i, valid, pc, instr, e.pc, e.instr);
      else n_pass++;
      tick();
      exp_count++;
    end
    n_checks++;
    if ({count, addr} !== {exp_count, mpc})
      $display("FAIL b2b_count: count=%h addr=%h, want %h %h", count, addr, exp_count, mpc);
    else n_pass++;
  endtask

  task automatic test_redirect_wait();
    bit ok;
    wait_req(ok);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    n_checks++;
    if (clr !== 1'b1) $display("FAIL rw_clr: clr=%b want 1", clr); else n_pass++;
    tick();
    redirect = 1'b0;
    rvalid = 1'b1;
    rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0;
    mpc = 32'h0000_0100;
    n_checks++;
    if ({valid, req, addr, count} !== {1'b0, 1'b1, mpc, exp_count})
      $display("FAIL rw_discard: valid=%b req=%b addr=%h count=%h, want 0 1 %h %h",
               valid, req, addr, count, mpc, exp_count);
    else n_pass++;
  endtask

  task automatic test_redirect_req();
    bit ok;
    exp_t e;
    wait_req(ok);
    gnt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    #1;
    n_checks++;
    if (clr !== 1'b1) $display("FAIL rr_clr: clr=%b want 1", clr); else n_pass++;
    tick();
    gnt = 1'b0;
    redirect = 1'b0;
    rvalid = 1'b1;
    rdata = 32'h1111_2222;
    tick();
    rvalid = 1'b0;
    mpc = 32'h0000_0200;
    n_checks++;
    if ({valid, req, addr, clr} !== {1'b0, 1'b1, mpc, 1'b0})
      $display("FAIL rr_discard: valid=%b req=%b addr=%h clr=%b, want 0 1 %h 0", valid, req, addr, clr, mpc);
    else n_pass++;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0304;
    tick();
    redirect = 1'b0;
    mpc = 32'h0000_0304;
    n_checks++;
    if ({req, addr} !== {1'b1, mpc})
      $display("FAIL rr_nognt: req=%b addr=%h, want 1 %h", req, addr, mpc);
    else n_pass++;
    stall = 1'b1;
    fetch(32'h0BAD_F00D, 0, ok);
    pop_exp(e, ok);
    n_checks++;
    if (!ok || {valid, pc, instr} !== {1'b1, e.pc, e.instr})
      $display("FAIL rv_out: valid=%b pc=%h instr=%h, want 1 %h %h", valid, pc, instr, e.pc, e.instr);
    else n_pass++;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    mpc = 32'h0000_0400;
    n_checks++;
    if ({valid, req, addr, count} !== {1'b0, 1'b1, mpc, exp_count})
      $display("FAIL rv_drop: valid=%b req=%b addr=%h count=%h, want 0 1 %h %h",
               valid, req, addr, count, mpc, exp_count);
    else n_pass++;
    rvalid = 1'b1;
    rdata = 32'h5555_AAAA;
    tick();
    rvalid = 1'b0;
    n_checks++;
    if ({valid, req, addr} !== {1'b0, 1'b1, mpc})
      $display("FAIL stray_rvalid: valid=%b req=%b addr=%h, want 0 1 %h", valid, req, addr, mpc);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    exp_t e;
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    tick();
    redirect = 1'b0;
    mpc = 32'hFFFF_FFFC;
    n_checks++;
    if ({req, addr} !== {1'b1, mpc})
      $display("FAIL wrap_align: req=%b addr=%h, want 1 %h", req, addr, mpc);
    else n_pass++;
    force dut.r_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_count;
    exp_count = 32'hFFFF_FFFF;
    fetch(32'h7777_0001, 1, ok);
    pop_exp(e, ok);
    n_checks++;
    if (!ok || {valid, pc, instr} !== {1'b1, e.pc, e.instr})
      $display("FAIL wrap_out: valid=%b pc=%h instr=%h, want 1 %h %h", valid, pc, instr, e.pc, e.instr);
    else n_pass++;
    tick();
    exp_count++;
    n_checks++;
    if ({count, req, addr} !== {exp_count, 1'b1, mpc})
      $display("FAIL wrap_count: count=%h req=%b addr=%h, want %h 1 %h", count, req, addr, exp_count, mpc);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    exp_t e;
    wait_req(ok);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    rvalid = 1'b1;
    rdata = 32'hCAFE_0000;
    n_checks++;
    if ({req, valid, instr, pc, count, addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0, RST_PC})
      $display("FAIL rst_async: req=%b valid=%b instr=%h pc=%h count=%h addr=%h, want 0 0 0 0 0 %h",
               req, valid, instr, pc, count, addr, RST_PC);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    rvalid = 1'b0;
    mpc = RST_PC;
    exp_count = '0;
    n_checks++;
    if ({valid, req, addr, count} !== {1'b0, 1'b1, mpc, exp_count})
      $display("FAIL rst_release: valid=%b req=%b addr=%h count=%h, want 0 1 %h %h",
               valid, req, addr, count, mpc, exp_count);
    else n_pass++;
    fetch(32'h0000_0093, 1, ok);
    pop_exp(e, ok);
    n_checks++;
    if (!ok || {valid, pc, instr} !== {1'b1, e.pc, e.instr})
      $display("FAIL rst_refetch: valid=%b pc=%h instr=%h, want 1 %h %h", valid, pc, instr, e.pc, e.instr);
    else n_pass++;
    tick();
    exp_count++;
    n_checks++;
    if ({count, addr} !== {exp_count, mpc})
      $display("FAIL rst_count: count=%h addr=%h, want %h %h", count, addr, exp_count, mpc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_req();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
